soc_system_pll_rst_seq: RTL

Reset/lock sequencer that drives the system PLL's reset input and consumes its asynchronous locked output. Runs on the free-running 50 MHz reference clock. It pulses PLL reset and qualifies lock with a filter and retry timeout. It then produces a single registered system reset request that downstream per-clock-domain reset synchronizers consume, plus status and counters for the HPS/CSR side.

---
 rtl/soc_system_pll_rst_pkg.sv | 29 ++
 rtl/soc_system_sync2.sv | 27 ++
 rtl/soc_system_pll_rst_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/soc_system_pll_rst_pkg.sv
// Shared types and helpers for the system PLL reset/lock sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package soc_system_pll_rst_pkg;

    // Sequencer states; encodings are visible on the status port
    typedef enum logic [2:0] {
        ST_PLL_RST      = 3'd0,
        ST_WAIT_LOCK    = 3'd1,
        ST_FILTER       = 3'd2,
        ST_RELEASE_WAIT = 3'd3,
        ST_RUN          = 3'd4
    } seq_state_e;

    // Width of the shared dwell counter. The counter only has to reach
    // (largest dwell - 1) because it is compared against that last value.
    function automatic int seq_cnt_width(input int pll_rst_cycles,
                                         input int lock_filter_cycles,
                                         input int release_delay,
                                         input int timeout_cycles);
        int m;
        m = pll_rst_cycles;
        if (lock_filter_cycles > m) m = lock_filter_cycles;
        if (release_delay > m)      m = release_delay;
        if (timeout_cycles > m)     m = timeout_cycles;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/soc_system_sync2.sv
// Generic 2-flop single-bit synchronizer with synchronous clear to 0.
// Latency: 2 clk_i edges from d_i capture to q_o.
// Backpressure: none; free-running sampler.
module soc_system_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/soc_system_pll_rst_seq.sv
// System PLL reset pulse generator, lock qualifier and system reset request.
// Latency: lock seen at edge E -> ready at E+2+LOCK_FILTER_CYCLES+RELEASE_DELAY.
// Backpressure: none; relock_req is a fire-and-forget single-cycle request.
module soc_system_pll_rst_seq
    import soc_system_pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_FILTER_CYCLES = 1024,
    parameter int RELEASE_DELAY      = 8,
    parameter int TIMEOUT_CYCLES     = 65536,
    parameter int CNT_W              = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked_async,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int CW = seq_cnt_width(PLL_RST_CYCLES, LOCK_FILTER_CYCLES,
                                      RELEASE_DELAY, TIMEOUT_CYCLES);

    // Last counter value of each dwell; the transition happens on that cycle
    localparam logic [CW-1:0] PLL_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] FLT_LAST = CW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_DELAY - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CNT_W-1:0] EVT_ONE = CNT_W'(1);

    logic             locked_s;
    seq_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pll_rst_q, sys_rst_q, ready_q;
    logic [CNT_W-1:0] lock_loss_q, lock_loss_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic             loss_evt, tmo_evt;

    // The only consumer of the asynchronous locked signal
    soc_system_sync2 u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked_async),
        .q_o   (locked_s)
    );

    // Next state, dwell counter and event detection
    always_comb begin
        state_d  = state_q;
        loss_evt = 1'b0;
        tmo_evt  = 1'b0;
        if (relock_req && (state_q != ST_PLL_RST)) begin
            // Relock wins over everything, but a coincident loss in RUN is still recorded
            state_d  = ST_PLL_RST;
            loss_evt = (state_q == ST_RUN) && !locked_s;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_FILTER;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = ST_PLL_RST;
                        tmo_evt = 1'b1;
                    end
                end
                ST_FILTER: begin
                    if (!locked_s)             state_d = ST_WAIT_LOCK;
                    else if (cnt_q == FLT_LAST) state_d = ST_RELEASE_WAIT;
                end
                ST_RELEASE_WAIT: begin
                    if (!locked_s)             state_d = ST_WAIT_LOCK;
                    else if (cnt_q == REL_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d  = ST_PLL_RST;
                        loss_evt = 1'b1;
                    end
                end
                default: state_d = ST_PLL_RST;
            endcase
        end

        // Counter restarts on any state change; it has no use while in RUN so it holds there
        if (state_d != state_q)    cnt_d = '0;
        else if (state_q == ST_RUN) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + CNT_ONE;

        lock_loss_d = lock_loss_q;
        if (loss_evt && (lock_loss_q != '1)) lock_loss_d = lock_loss_q + EVT_ONE;
        timeout_d = timeout_q;
        if (tmo_evt && (timeout_q != '1)) timeout_d = timeout_q + EVT_ONE;
    end

    // State, counters and Moore outputs, all updated on the same edge
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_loss_q <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= (state_d == ST_PLL_RST);
            sys_rst_q   <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            lock_loss_q <= lock_loss_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lock_loss_cnt = lock_loss_q;
    assign timeout_cnt   = timeout_q;

endmodule
